pipe_stage_skid_reg: RTL
========================

Name: pipe_stage_skid_reg

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers: one generic stage register carrying a packed payload of DATA_W bits between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the global write-enable stall with a per-stage valid/ready handshake and a one-entry skid buffer, so the upstream ready path is fully registered.
- Keeps flush (kill whole stage) and generalises the per-field branch-prediction clear into a masked partial clear.
- Adds occupancy and stall-cycle observability.

Parameters:
- DATA_W, 64, payload width in bits (caller packs pc, operands, decode fields).
- CLR_MASK, {DATA_W{1'b0}}, bit mask of payload bits forced to 0 on capture when in_pclr is high (e.g. the predicted-taken bit).
- STALL_CNT_W, 16, width of the saturating back-pressure counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_data  input  DATA_W  upstream payload.
- in_pclr  input  1  apply CLR_MASK to in_data on this capture.
- out_valid  output  1  main register holds a valid payload.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_W  main register payload; all zeros when out_valid=0.
- flush  input  1  synchronous kill of all stage contents.
- occupancy  output  2  number of valid entries, 0..2.
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Handshake definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - Capture value cap = in_pclr ? (in_data & ~CLR_MASK) : in_data.
- Storage: main (main_valid, main_data) and skid (skid_valid, skid_data). out_valid=main_valid; out_data=main_data.
- State encoding via occupancy:
  - EMPTY (0): main invalid, skid invalid.
  - ONE (1): main valid, skid invalid.
  - TWO (2): main valid, skid valid.
- EMPTY transitions:
  - in_fire: main<=cap, go to ONE.
  - Otherwise stay in EMPTY.
- ONE transitions:
  - in_fire & out_fire: main<=cap, stay in ONE.
  - in_fire & !out_fire: skid<=cap, go to TWO.
  - !in_fire & out_fire: main cleared, go to EMPTY.
  - Neither: hold.
- TWO transitions:
  - in_ready=0, so no capture is possible.
  - out_fire: main<=skid_data, skid cleared, go to ONE.
  - Otherwise hold.
- Ordering: payloads leave in arrival order. Latency is 1 cycle from in_fire to out_valid when EMPTY or draining. Throughput is 1 payload per cycle when out_ready is held high.
- Invalid entries always hold all-zero data (bubble value); the cleared entry is zeroed on the same edge.
- flush has highest priority:
  - On a flush edge, main and skid are both invalidated and zeroed; next state is EMPTY.
  - in_data presented in the flush cycle is discarded, even if in_fire=1.
  - The downstream may still see out_fire in that cycle; the payload counts as consumed.
- in_pclr affects only the beat being captured. It never touches stored entries and is ignored when in_fire=0.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & !out_ready.
  - Holds at all-ones.
  - Not cleared by flush; cleared only by rst.
- Reset values (immediately on rst assertion, independent of clk):
  - main_valid=0, skid_valid=0, both data regs 0.
  - out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0.
- Reset mid-transfer: all in-flight payloads are lost; no partial capture on the edge where rst deasserts.
- in_valid without in_ready: upstream must hold in_valid and in_data stable; the stage does not capture.
- The DATA_W=1 corner must be legal; CLR_MASK wider or narrower than DATA_W is illegal.

Test Plan:
- Reset then stream: assert rst asynchronously mid-cycle; drive in_valid=1 with data 0x1, 0x2, 0x3 and out_ready=1. Required: out_data shows 1, 2, 3 on consecutive cycles starting 1 cycle after first fire; occupancy=1; stall_cnt=0.
- Back-pressure fill:
  - Setup: out_ready=0; send 0xA then 0xB.
  - After the first two fires: occupancy=2, in_ready=0, out_data=0xA.
  - Holding 0xC does not fire.
  - Raise out_ready: order is 0xA, 0xB, 0xC.
  - stall_cnt equals the number of cycles out_ready was 0 while out_valid was 1.
- Partial clear: DATA_W=8, CLR_MASK=0x01; capture 0xFF with in_pclr=1, then 0xFF with in_pclr=0. Required: out_data 0xFE then 0xFF.
- Flush in TWO: occupancy=2, flush=1 together with in_valid=1, data 0x55. Required next cycle: occupancy=0, out_valid=0, out_data=0, in_ready=1; 0x55 never appears.
- Saturation: STALL_CNT_W=4; hold out_valid=1, out_ready=0 for 20 cycles. Required: stall_cnt=0xF and held; flush leaves it at 0xF; rst returns it to 0.
- Simultaneous fire in ONE: main=0x10; in_fire with 0x20 and out_fire in the same cycle. Required: occupancy stays 1, out_data=0x20 next cycle, skid untouched (in_ready stays 1).

Source files
------------

// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for one generic pipeline stage register.
// The slave side is the stage itself. The master side is the
// environment that drives the upstream beat, downstream ready and flush.
interface pipe_stage_skid_reg_if #(
    parameter int DATA_W      = 64,
    parameter int STALL_CNT_W = 16
);
    // Upstream beat
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_data;
    logic                   in_pclr;

    // Downstream beat
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_W-1:0]      out_data;

    // Control and observability
    logic                   flush;
    logic [1:0]             occupancy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_data, in_pclr, out_ready, flush,
        output in_ready, out_valid, out_data, occupancy, stall_cnt
    );

    modport master (
        output in_valid, in_data, in_pclr, out_ready, flush,
        input  in_ready, out_valid, out_data, occupancy, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with a valid/ready handshake and a
// one-entry skid buffer. Upstream ready is a pure decode of registered state,
// so it has no combinational path from out_ready. Flush kills the whole
// stage. A masked partial clear can zero selected payload bits on capture.
// A saturating counter records back-pressure cycles.
module pipe_stage_skid_reg #(
    parameter int DATA_W      = 64,
    parameter     CLR_MASK    = {DATA_W{1'b0}},
    parameter int STALL_CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    pipe_stage_skid_reg_if.slave         bus
);

    // A partial-clear mask that does not match the payload width is a
    // configuration error, not something to silently truncate or extend.
    if ($bits(CLR_MASK) != DATA_W) begin : g_bad_clr_mask
        $error("pipe_stage_skid_reg: CLR_MASK width must equal DATA_W");
    end

    localparam logic [DATA_W-1:0] CLR_MASK_V = CLR_MASK;

    // The occupancy count doubles as the state encoding:
    // main valid = not EMPTY, skid valid = TWO.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DATA_W-1:0]      r_main_data;
    logic [DATA_W-1:0]      r_skid_data;
    logic [DATA_W-1:0]      w_main_nxt;
    logic [DATA_W-1:0]      w_skid_nxt;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic                   w_main_valid;
    logic                   w_in_ready;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_stall;
    logic [DATA_W-1:0]      w_cap;

    // Handshake decode from registered state only
    assign w_main_valid = (r_state != ST_EMPTY);
    assign w_in_ready   = (r_state != ST_TWO);
    assign w_in_fire    = bus.in_valid & w_in_ready;
    assign w_out_fire   = w_main_valid & bus.out_ready;
    assign w_stall      = w_main_valid & ~bus.out_ready;

    // The partial clear applies only to the beat being captured now
    assign w_cap = bus.in_pclr ? (bus.in_data & ~CLR_MASK_V) : bus.in_data;

    // Next-state and next-payload selection; flush overrides every transition
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = r_skid_data;

        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = '0;
            w_skid_nxt  = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_nxt  = w_cap;
                        w_state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // Pass-through: old main leaves, new beat replaces it
                        w_main_nxt = w_cap;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new beat in the skid
                        w_skid_nxt  = w_cap;
                        w_state_nxt = ST_TWO;
                    end else if (w_out_fire) begin
                        w_main_nxt  = '0;
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only the drain path exists
                    if (w_out_fire) begin
                        w_main_nxt  = r_skid_data;
                        w_skid_nxt  = '0;
                        w_state_nxt = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = '0;
                    w_skid_nxt  = '0;
                end
            endcase
        end
    end

    // State and payload registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the payload registers are reset as well as the valid state,
        // because an invalid entry must always read back as an all-zero bubble.
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // pre-edge values and the block order cannot change behaviour.
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
            r_skid_data <= w_skid_nxt;
        end
    end

    // Saturating back-pressure counter; flush does not clear it, only rst does
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_main_valid;
    assign bus.out_data  = r_main_data;
    assign bus.occupancy = r_state;
    assign bus.stall_cnt = r_stall_cnt;

endmodule
